// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Bank of NUM_CH independent event counters feeding the LED / seven-segment
//   display path. Each channel counts its event strobe when the global gate is
//   open and it is not masked off by a pipeline stall. Counters either wrap or
//   saturate. Each channel has a sticky overflow flag and a snapshot shadow
//   register. One registered 32-bit display word is selected from the
//   pass-through data, a live counter or a snapshot copy.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset, overrides every other input
//   data_in    32-bit pass-through display word
//   event_in   per-channel event strobes (NUM_CH)
//   gate       global count enable
//   stall      pipeline stall, applied to channels whose STALL_MASK bit is set
//   sat_mode   0 = wrap, 1 = saturate at all-ones
//   clear      zero all counters and overflow flags (shadows are kept)
//   snap       copy all live counters into their shadows
//   show_snap  counter selects read shadows instead of live counters
//   select     0 = data_in, k in 1..NUM_CH = channel k-1, anything else = 0
//   data_out   registered display word, counters zero-extended
//   overflow   sticky per-channel overflow flags

// One counter channel: live count, shadow copy and sticky overflow.
module perf_counter_lane #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             sat_mode,
    input  logic             clear,
    input  logic             snap,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        // Shadow always captures the value held before this edge's update,
        // so a same-cycle clear or increment does not leak into it.
        shadow_d = snap ? cnt_q : shadow_q;
        if (clear) begin
            // Clear wins over a same-cycle increment.
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = sat_mode ? CNT_MAX : '0;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt    = cnt_q;
    assign shadow = shadow_q;
    assign ovf    = ovf_q;
endmodule

module perf_counter_bank #(
    parameter int                NUM_CH     = 4,
    parameter int                CNT_W      = 32,
    parameter logic [NUM_CH-1:0] STALL_MASK = '0,
    parameter int                SEL_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_in,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              gate,
    input  logic              stall,
    input  logic              sat_mode,
    input  logic              clear,
    input  logic              snap,
    input  logic              show_snap,
    input  logic [SEL_W-1:0]  select,
    output logic [31:0]       data_out,
    output logic [NUM_CH-1:0] overflow
);
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow;
    logic [NUM_CH-1:0]            inc;
    logic [31:0]                  data_out_q, data_out_d;

    assign inc = event_in & {NUM_CH{gate}} & ~({NUM_CH{stall}} & STALL_MASK);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        perf_counter_lane #(.CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[i]),
            .sat_mode (sat_mode),
            .clear    (clear),
            .snap     (snap),
            .cnt      (cnt[i]),
            .shadow   (shadow[i]),
            .ovf      (overflow[i])
        );
    end

    // Display mux: select 0 passes data_in, 1..NUM_CH picks a channel,
    // out-of-range selects show zero.
    always_comb begin
        data_out_d = '0;
        if (select == '0) begin
            data_out_d = data_in;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (select == SEL_W'(i + 1)) begin
                    data_out_d[CNT_W-1:0] = show_snap ? shadow[i] : cnt[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) data_out_q <= '0;
        else     data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int SEL_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       data_in;
    logic [NUM_CH-1:0] event_in;
    logic              gate, stall, sat_mode, clear, snap, show_snap;
    logic [SEL_W-1:0]  select;
    logic [31:0]       data_out;
    logic [NUM_CH-1:0] overflow;

    int n_tests = 0;
    int n_fail  = 0;

    perf_counter_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .STALL_MASK(4'b1000), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .event_in(event_in),
        .gate(gate), .stall(stall), .sat_mode(sat_mode), .clear(clear),
        .snap(snap), .show_snap(show_snap), .select(select),
        .data_out(data_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stop events, point the mux at a live channel and read it after one edge.
    task automatic read_ch(input int ch, input string tag, input logic [31:0] exp);
        event_in  = '0;
        show_snap = 1'b0;
        select    = SEL_W'(ch + 1);
        tick();
        chk(tag, data_out, exp);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_in = '0; event_in = '0; gate = 1'b0; stall = 1'b0;
        sat_mode = 1'b0; clear = 1'b0; snap = 1'b0; show_snap = 1'b0; select = '0;

        // Reset and clear
        tick(2);
        chk("reset_dout", data_out, 32'h0);
        chk("reset_ovf", {28'h0, overflow}, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_reset_dout", data_out, 32'h0);
        do_clear();
        read_ch(0, "clear_ch0", 32'd0);

        // Gating: 10 event cycles, stall on 3 of them masks ch3 only
        gate = 1'b1;
        event_in = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            stall = (i >= 3 && i < 6);
            tick();
        end
        stall = 1'b0;
        read_ch(0, "gate_ch0", 32'd10);
        read_ch(1, "gate_ch1", 32'd10);
        read_ch(2, "gate_ch2", 32'd10);
        read_ch(3, "gate_ch3", 32'd7);

        // Same sequence with gate closed
        do_clear();
        gate = 1'b0;
        event_in = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            stall = (i >= 3 && i < 6);
            tick();
        end
        stall = 1'b0;
        read_ch(0, "nogate_ch0", 32'd0);
        read_ch(3, "nogate_ch3", 32'd0);

        // Wrap: 254 events to preload, then 3 more -> 1
        gate = 1'b1;
        sat_mode = 1'b0;
        event_in = 4'b0001;
        tick(254);
        read_ch(0, "preload_254", 32'd254);
        chk("preload_ovf", {28'h0, overflow}, 32'h0);
        event_in = 4'b0001;
        tick(3);
        read_ch(0, "wrap_ch0", 32'd1);
        chk("wrap_ovf", {28'h0, overflow}, 32'h1);

        // Saturate: same sequence -> sticks at 255
        do_clear();
        sat_mode = 1'b1;
        event_in = 4'b0001;
        tick(257);
        read_ch(0, "sat_ch0", 32'd255);
        chk("sat_ovf", {28'h0, overflow}, 32'h1);
        // Switching mode leaves the stored value and flag alone
        sat_mode = 1'b0;
        read_ch(0, "mode_switch_ch0", 32'd255);
        chk("mode_switch_ovf", {28'h0, overflow}, 32'h1);
        do_clear();
        read_ch(0, "sat_clear_ch0", 32'd0);
        chk("sat_clear_ovf", {28'h0, overflow}, 32'h0);

        // Clear beats a same-cycle increment
        event_in = 4'b0001;
        tick(5);
        read_ch(0, "pre_clr_ch0", 32'd5);
        clear = 1'b1;
        event_in = 4'b0001;
        tick();
        clear = 1'b0;
        read_ch(0, "clr_vs_inc", 32'd0);
        event_in = 4'b0001;
        tick();
        read_ch(0, "after_clr_inc", 32'd1);

        // Snapshot: ch1 reaches 20, snap together with an event
        do_clear();
        event_in = 4'b0010;
        tick(20);
        snap = 1'b1;
        tick();                 // ch1 -> 21, shadow1 <- 20
        snap = 1'b0;
        show_snap = 1'b1;
        select = 4'd2;
        tick();                 // ch1 -> 22, data_out <- shadow1
        chk("snap_shadow", data_out, 32'd20);
        show_snap = 1'b0;
        tick();                 // data_out <- live 22, ch1 -> 23
        chk("snap_live", data_out, 32'd22);
        read_ch(1, "live_adv", 32'd23);
        // Clear does not touch the shadow
        do_clear();
        show_snap = 1'b1;
        select = 4'd2;
        tick();
        chk("shadow_keep", data_out, 32'd20);
        read_ch(1, "live_cleared", 32'd0);

        // Mux coverage
        data_in = 32'hDEAD_BEEF;
        select = 4'd0;
        tick();
        chk("mux_pass", data_out, 32'hDEAD_BEEF);
        select = 4'd5;
        tick();
        chk("mux_sel5", data_out, 32'h0);
        select = 4'd15;
        tick();
        chk("mux_sel15", data_out, 32'h0);

        // Reset mid-count, then the release edge counts
        event_in = 4'b0001;
        rst = 1'b1;
        tick();
        chk("rst_mid_dout", data_out, 32'h0);
        rst = 1'b0;
        tick();
        read_ch(0, "rst_release_cnt", 32'd1);
        show_snap = 1'b1;
        select = 4'd2;
        tick();
        chk("rst_shadow", data_out, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
